// File: rtl/mem_fifo_ctrl_pkg.sv
// mem_fifo_pkg: shared types and default widths for the memory-backed
// sample FIFO controller (mem_fifo_ctrl).
package mem_fifo_pkg;

  // Access sequencer states. A write takes one memory cycle and a read
  // takes two (address phase, then data phase).
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_ADDR = 2'd2,
    READ_DATA = 2'd3
  } state_t;

  // Default geometry of the external 8M x 16 sample memory.
  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 16;

endpackage : mem_fifo_pkg

// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: uses a single-port synchronous-read memory as a circular
// sample FIFO between a valid/ready write stream and a valid/ready read
// stream. Reads have priority over writes. Memory control outputs are decoded
// from registered state only, so stream inputs never reach mem_* directly.
//
// Optional build macro MEM_FIFO_LEVEL_EN adds the 'level' (current word count)
// and sticky 'overflow' outputs; without it those ports and their logic are
// absent.
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    DEPTH_LOG2 = 23,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
`ifdef MEM_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
`endif
);

  // Count value meaning every slot of the ring is occupied.
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_out_free;
  logic                    w_rd_need;
  logic                    w_in_ready;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // The output holding register is free when it is empty or being drained
  // at this edge; a stored word then needs to be fetched into it.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_rd_need  = w_out_free && !w_empty;

  // Writes are only taken from IDLE and yield to any pending read.
  assign w_in_ready = (r_state == IDLE) && !w_full && !w_rd_need && !flush && !reset;
  assign w_accept   = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Ring pointers mapped into the FIFO region of the memory; the sum wraps
  // at the memory address width.
  assign w_wr_addr = BASE_ADDR + ADDR_WIDTH'(r_wr_ptr);
  assign w_rd_addr = BASE_ADDR + ADDR_WIDTH'(r_rd_ptr);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush forces IDLE from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_need) begin
            w_state_nxt = READ_ADDR;
          end else if (w_accept) begin
            w_state_nxt = WRITE;
          end
        end
        WRITE:     w_state_nxt = IDLE;
        READ_ADDR: w_state_nxt = READ_DATA;
        READ_DATA: w_state_nxt = IDLE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  // Memory interface decode from state and pointer registers only.
  always_comb begin
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (r_state)
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = w_wr_addr;
        mem_din  = r_wdata;
      end
      READ_ADDR, READ_DATA: begin
        mem_oe   = 1'b1;
        mem_addr = w_rd_addr;
      end
      default: begin
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
      end
    endcase
  end

  // Ring pointers and occupancy: count only rises in WRITE and only falls in
  // READ_DATA, so the two never collide. A write in flight at a flush still
  // pulses mem_we but its slot is forgotten here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (r_state == WRITE) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end else if (r_state == READ_DATA) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= r_count - 1'b1;
      end
    end
  end

  // Capture the accepted stream word so it can be presented during WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wdata <= in_data;
    end
  end

  // Output holding register: loaded at the end of the read data phase,
  // emptied on a handshake, otherwise held stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (r_state == READ_DATA) begin
      r_out_valid <= 1'b1;
      r_out_data  <= mem_dout;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MEM_FIFO_LEVEL_EN
  logic r_overflow;

  assign level    = r_count;
  assign overflow = r_overflow;

  // Sticky record of a write offered while no space was available.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (in_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end
`endif

endmodule : mem_fifo_ctrl

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl: directed bench for mem_fifo_ctrl with a 16-deep FIFO
// placed at 23'h000100, using a behavioural synchronous-read memory as the
// responder.
module tb_mem_fifo_ctrl;
  import mem_fifo_pkg::*;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int DL = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          mem_we;
  logic          mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
`ifdef MEM_FIFO_LEVEL_EN
  logic [DL:0]   level;
  logic          overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH_LOG2 (DL),
    .BASE_ADDR  (23'h000100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_we    (mem_we),
    .mem_oe    (mem_oe),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
`ifdef MEM_FIFO_LEVEL_EN
    ,
    .level     (level),
    .overflow  (overflow)
`endif
  );

  // Synchronous-read memory responder; only the low address bits are
  // decoded since the FIFO region is small. Undriven bus modelled as 0.
  logic [DW-1:0] mem_arr [0:511];
  logic [DW-1:0] mem_q;
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr[8:0]] <= mem_din;
    if (mem_oe) mem_q <= mem_arr[mem_addr[8:0]];
  end
  assign mem_dout = mem_oe ? mem_q : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted; returns just
  // after the accepting edge.
  task automatic push(input logic [DW-1:0] d);
    int i;
    in_valid = 1'b1;
    in_data  = d;
    #0;
    for (i = 0; i < 20 && !in_ready; i++) step();
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%0b required 1 for data %h", in_ready, d);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mem_oe: got %b want 0", mem_oe); end
    n_checks++; if (mem_addr !== 23'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    push(16'hA5A5);
    // cycle N+1: WRITE
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", mem_we); end
    n_checks++; if (mem_addr !== 23'h000100) begin n_fail++; $display("FAIL single_waddr: got %h want 000100", mem_addr); end
    n_checks++; if (mem_din !== 16'hA5A5) begin n_fail++; $display("FAIL single_din: got %h want a5a5", mem_din); end
    step();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL single_we_pulse: got %b want 0", mem_we); end
    step();
    n_checks++; if (mem_oe !== 1'b1 || mem_addr !== 23'h000100) begin n_fail++; $display("FAIL single_raddr: oe=%b addr=%h want oe=1 addr=000100", mem_oe, mem_addr); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'hA5A5) begin n_fail++; $display("FAIL single_out: valid=%b data=%h want 1/a5a5", out_valid, out_data); end
    n_checks++; if (dut.r_count !== 5'd0) begin n_fail++; $display("FAIL single_count: got %0d want 0", dut.r_count); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_fill_full();
    int rcv;
    bit extra_write;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) push(DW'(k));
    step();
    n_checks++; if (dut.r_count !== 5'd15) begin n_fail++; $display("FAIL fill_count15: got %0d want 15", dut.r_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready15: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin n_fail++; $display("FAIL fill_head: valid=%b data=%h want 1/0000", out_valid, out_data); end
    push(16'h0010);
    step();
    n_checks++; if (dut.r_count !== 5'd16) begin n_fail++; $display("FAIL fill_count16: got %0d want 16", dut.r_count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 16'h0011;
    extra_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (mem_we || in_ready) extra_write = 1'b1;
      step();
    end
    n_checks++; if (extra_write !== 1'b0) begin n_fail++; $display("FAIL full_no_write: got %b want 0", extra_write); end
`ifdef MEM_FIFO_LEVEL_EN
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b want 1", overflow); end
    n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d want 16", level); end
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    rcv = 0;
    for (int i = 0; i < 300 && rcv < 17; i++) begin
      if (out_valid) begin
        n_checks++; if (out_data !== DW'(rcv)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", rcv, out_data, DW'(rcv)); end
        rcv++;
      end
      step();
    end
    n_checks++; if (rcv !== 17) begin n_fail++; $display("FAIL drain_words: got %0d want 17", rcv); end
    n_checks++; if (dut.r_count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", dut.r_count); end
  endtask

  task automatic test_wrap();
    int sent;
    int rcv;
    int bad;
    bit saw_wrap;
    logic [AW-1:0] prev_wr;
    sent = 0; rcv = 0; bad = 0; saw_wrap = 1'b0; prev_wr = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 800 && rcv < 40; i++) begin
      in_valid = (sent < 40);
      in_data  = 16'h2000 + DW'(sent);
      #1;
      if (mem_we) begin
        if (prev_wr == 23'h00010F && mem_addr == 23'h000100) saw_wrap = 1'b1;
        prev_wr = mem_addr;
      end
      if (out_valid) begin
        if (out_data !== 16'h2000 + DW'(rcv)) begin
          bad++;
          $display("FAIL wrap_data[%0d]: got %h want %h", rcv, out_data, 16'h2000 + DW'(rcv));
        end
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    n_checks++; if (bad != 0) n_fail++;
    n_checks++; if (rcv !== 40) begin n_fail++; $display("FAIL wrap_count: got %0d want 40", rcv); end
    n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_addr: saw wrap %b want 1", saw_wrap); end
  endtask

  task automatic test_backpressure();
    bit stable;
    bit extra_rd;
    out_ready = 1'b0;
    push(16'h0B01);
    push(16'h0B02);
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0B01) begin n_fail++; $display("FAIL bp_head: valid=%b data=%h want 1/0b01", out_valid, out_data); end
    n_checks++; if (dut.r_count !== 5'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", dut.r_count); end
    stable = 1'b1; extra_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_data !== 16'h0B01) stable = 1'b0;
      if (mem_oe) extra_rd = 1'b1;
      step();
    end
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b want 1", stable); end
    n_checks++; if (extra_rd !== 1'b0) begin n_fail++; $display("FAIL bp_no_read: got %b want 0", extra_rd); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0 || mem_oe !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b oe=%b want 0/1", out_valid, mem_oe); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap: got %b want 0", out_valid); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0B02) begin n_fail++; $display("FAIL bp_next: valid=%b data=%h want 1/0b02", out_valid, out_data); end
    step();
  endtask

  task automatic test_flush_mid_read();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(16'h00F0 + DW'(k));
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (dut.r_count !== 5'd5 || out_data !== 16'h00F0) begin n_fail++; $display("FAIL flush_setup: count=%0d data=%h want 5/00f0", dut.r_count, out_data); end
    out_ready = 1'b1;
    step();
    n_checks++; if (dut.r_state !== READ_ADDR || mem_oe !== 1'b1) begin n_fail++; $display("FAIL flush_in_read: state=%0d oe=%b want 2/1", dut.r_state, mem_oe); end
    flush = 1'b1;
    out_ready = 1'b0;
    #0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    n_checks++; if (dut.r_count !== 5'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", dut.r_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (mem_oe !== 1'b0) begin n_fail++; $display("FAIL flush_oe: got %b want 0", mem_oe); end
    n_checks++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL flush_state: got %0d want 0", dut.r_state); end
    out_ready = 1'b1;
    push(16'h1234);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 23'h000100 || mem_din !== 16'h1234) begin n_fail++; $display("FAIL flush_rewrite: we=%b addr=%h din=%h want 1/000100/1234", mem_we, mem_addr, mem_din); end
    step();
    step();
    n_checks++; if (mem_oe !== 1'b1 || mem_addr !== 23'h000100) begin n_fail++; $display("FAIL flush_reread_addr: oe=%b addr=%h want 1/000100", mem_oe, mem_addr); end
    step();
    step();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin n_fail++; $display("FAIL flush_readback: valid=%b data=%h want 1/1234", out_valid, out_data); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    push(16'h7777);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL arst_pre_we: got %b want 1", mem_we); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 23'h0 || mem_din !== 16'h0 || mem_oe !== 1'b0) begin n_fail++; $display("FAIL arst_mem: addr=%h din=%h oe=%b want 0/0/0", mem_addr, mem_din, mem_oe); end
    n_checks++; if (out_data !== 16'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_stream: data=%h valid=%b ready=%b want 0/0/0", out_data, out_valid, in_ready); end
    n_checks++; if (dut.r_count !== 5'd0 || dut.r_wr_ptr !== 4'd0 || dut.r_rd_ptr !== 4'd0) begin n_fail++; $display("FAIL arst_ptrs: count=%0d wr=%0d rd=%0d want 0/0/0", dut.r_count, dut.r_wr_ptr, dut.r_rd_ptr); end
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_release: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_full();
    test_wrap();
    test_backpressure();
    test_flush_mid_read();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_fifo_ctrl
